// File: rtl/sobel_stream_filter.sv
// rtl/sobel_stream_filter.sv - streaming 3x3 Sobel / pass-through filter, 3-cycle latency
// Optional SOBEL_THRESH_EN: stage 3 binarises filtered results against the frame-latched threshold.
module sobel_stream_filter #(
    parameter int DATA_W = 12,
    parameter int LINE_W = 640,
    parameter int ROW_W  = 10
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSOF,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic [1:0]        iMODE,
    input  logic [DATA_W-1:0] iTHRESH,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL,
    output logic              oBORDER
);
    localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int SUM_W = DATA_W + 4;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX  = '1;

    logic [COL_W-1:0]  col_cnt, col_cur;
    logic [ROW_W-1:0]  row_cnt, row_cur;
    logic [1:0]        mode_q, mode_cur;
    logic [DATA_W-1:0] lb1 [LINE_W];
    logic [DATA_W-1:0] lb2 [LINE_W];
    logic [DATA_W-1:0] lb1_rd, lb2_rd;
    logic [DATA_W-1:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic              s1_valid, s1_border;
    logic [1:0]        s1_mode;
    logic signed [SUM_W-1:0] gx_c, gy_c, s2_gx, s2_gy;
    logic              s2_valid, s2_border;
    logic [1:0]        s2_mode;
    logic [DATA_W-1:0] s2_pix;
    logic [SUM_W-1:0]  abs_x, abs_y, mag;
    logic [DATA_W-1:0] sat, res;
`ifdef SOBEL_THRESH_EN
    logic [DATA_W-1:0] thr_q, thr_cur, s1_thr, s2_thr;
`else
    logic              unused_thresh;
    assign unused_thresh = ^iTHRESH;
`endif

    // A start-of-frame pulse acts on the pixel that accompanies it.
    always_comb begin
        col_cur  = iSOF ? '0 : col_cnt;
        row_cur  = iSOF ? '0 : row_cnt;
        mode_cur = iSOF ? iMODE : mode_q;
    end
`ifdef SOBEL_THRESH_EN
    assign thr_cur = iSOF ? iTHRESH : thr_q;
`endif

    assign lb1_rd = lb1[col_cur];
    assign lb2_rd = lb2[col_cur];

    always_ff @(posedge iCLK) begin
        if (iDVAL) begin
            lb1[col_cur] <= iDATA;
            lb2[col_cur] <= lb1_rd;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            mode_q    <= '0;
            s1_valid  <= 1'b0;
            s1_border <= 1'b0;
            s1_mode   <= '0;
`ifdef SOBEL_THRESH_EN
            thr_q     <= '0;
            s1_thr    <= '0;
`endif
        end else begin
            if (iSOF) begin
                mode_q  <= iMODE;
                col_cnt <= '0;
                row_cnt <= '0;
`ifdef SOBEL_THRESH_EN
                thr_q   <= iTHRESH;
`endif
            end
            if (iDVAL) begin
                col_cnt   <= (col_cur == COL_LAST) ? '0 : col_cur + COL_W'(1);
                row_cnt   <= (col_cur == COL_LAST && row_cur != ROW_MAX) ? row_cur + ROW_W'(1) : row_cur;
                s1_mode   <= mode_cur;
                s1_border <= (mode_cur != 2'd0) && (int'(col_cur) < 2 || int'(row_cur) < 2);
`ifdef SOBEL_THRESH_EN
                s1_thr    <= thr_cur;
`endif
            end
            s1_valid <= iDVAL;
        end
    end

    // Row 0 of the window is image row y-2, column 2 is the newest column x.
    always_ff @(posedge iCLK) begin
        if (iDVAL) begin
            p00 <= p01; p01 <= p02; p02 <= lb2_rd;
            p10 <= p11; p11 <= p12; p12 <= lb1_rd;
            p20 <= p21; p21 <= p22; p22 <= iDATA;
        end
    end

    function automatic logic signed [SUM_W-1:0] ext(input logic [DATA_W-1:0] p);
        return signed'({4'b0000, p});
    endfunction

    always_comb begin
        gx_c = (ext(p02) + (ext(p12) <<< 1) + ext(p22)) - (ext(p00) + (ext(p10) <<< 1) + ext(p20));
        gy_c = (ext(p20) + (ext(p21) <<< 1) + ext(p22)) - (ext(p00) + (ext(p01) <<< 1) + ext(p02));
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge iCLK) begin
        s2_gx     <= gx_c;
        s2_gy     <= gy_c;
        s2_pix    <= p22;
        s2_mode   <= s1_mode;
        s2_border <= s1_border;
`ifdef SOBEL_THRESH_EN
        s2_thr    <= s1_thr;
`endif
    end

    // Pass-through emits the raw accepted pixel, aligned to the filter latency.
    always_comb begin
        abs_x = s2_gx[SUM_W-1] ? $unsigned(-s2_gx) : $unsigned(s2_gx);
        abs_y = s2_gy[SUM_W-1] ? $unsigned(-s2_gy) : $unsigned(s2_gy);
        case (s2_mode)
            2'd1:    mag = abs_x;
            2'd2:    mag = abs_y;
            default: mag = abs_x + abs_y;
        endcase
        sat = (|mag[SUM_W-1:DATA_W]) ? '1 : mag[DATA_W-1:0];
        if (s2_mode == 2'd0) begin
            res = s2_pix;
        end else if (s2_border) begin
            res = '0;
        end else begin
`ifdef SOBEL_THRESH_EN
            res = (sat >= s2_thr) ? '1 : '0;
`else
            res = sat;
`endif
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oDATA   <= '0;
            oDVAL   <= 1'b0;
            oBORDER <= 1'b0;
        end else begin
            oDATA   <= res;
            oDVAL   <= s2_valid;
            oBORDER <= s2_valid & s2_border;
        end
    end
endmodule

// File: tb/tb_sobel_stream_filter.sv
// tb/tb_sobel_stream_filter.sv - directed self-checking bench for sobel_stream_filter
module tb_sobel_stream_filter;
    localparam int DW  = 12;
    localparam int LW  = 8;
    localparam int THR = 300;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          b;
    } out_t;

    logic          clk = 1'b0;
    logic          rst, sof, dval;
    logic [DW-1:0] data, thresh;
    logic [1:0]    mode;
    logic [DW-1:0] o_data;
    logic          o_dval, o_border;

    int   n_checks = 0;
    int   n_errors = 0;
    logic [2:0] hist = 3'b000;
    out_t out_q[$];
    out_t exp_q[$];

    always #5 clk = ~clk;

    sobel_stream_filter #(.DATA_W(DW), .LINE_W(LW), .ROW_W(10)) dut (
        .iCLK(clk), .iRST(rst), .iSOF(sof), .iDATA(data), .iDVAL(dval),
        .iMODE(mode), .iTHRESH(thresh),
        .oDATA(o_data), .oDVAL(o_dval), .oBORDER(o_border)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Column and row profiles; every test image is a(x) + b(y).
    function automatic int av(input int kind, input int x);
        case (kind)
            0:       return x * 300;
            1:       return 1000;
            2:       return (x >= 4) ? 100 : 0;
            3:       return (x >= 4) ? 4095 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int bv(input int kind, input int y);
        case (kind)
            0:       return y * 11;
            4:       return (y >= 2) ? 200 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic out_t exp_px(input logic [1:0] fm, input int kind, input int x, input int y);
        out_t r;
        int gx, gy, mag;
        r.b = 1'b0;
        if (fm == 2'd0) begin
            r.d = DW'(av(kind, x) + bv(kind, y));
        end else if (x < 2 || y < 2) begin
            r.d = '0;
            r.b = 1'b1;
        end else begin
            gx = 4 * (av(kind, x) - av(kind, x - 2));
            gy = 4 * (bv(kind, y) - bv(kind, y - 2));
            if (gx < 0) gx = -gx;
            if (gy < 0) gy = -gy;
            mag = (fm == 2'd1) ? gx : (fm == 2'd2) ? gy : gx + gy;
            if (mag > 4095) mag = 4095;
`ifdef SOBEL_THRESH_EN
            r.d = (mag >= THR) ? 12'hFFF : 12'h000;
`else
            r.d = DW'(mag);
`endif
        end
        return r;
    endfunction

    // One clock: sample outputs at the falling edge, then drive the next inputs.
    task automatic cycle(input logic r, input logic s, input logic v, input logic [DW-1:0] d, input logic [1:0] m);
        @(negedge clk);
        check("odval_latency", 32'(o_dval), 32'(hist[2]));
        if (o_dval) out_q.push_back({o_data, o_border});
        hist = r ? 3'b000 : {hist[1:0], v};
        rst  = r;
        sof  = s;
        dval = v;
        data = d;
        mode = m;
    endtask

    task automatic compare(input string name);
        int n;
        repeat (4) cycle(1'b0, 1'b0, 1'b0, '0, mode);
        check({name, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data[%0d]", name, i), 32'(out_q[i].d), 32'(exp_q[i].d));
            check($sformatf("%s_border[%0d]", name, i), 32'(out_q[i].b), 32'(exp_q[i].b));
        end
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic run_frame(input string name, input int kind, input logic [1:0] fm,
                             input logic [1:0] late_mode, input int change_at, input bit gaps);
        int idx = 0;
        logic [1:0] m;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < LW; x++) begin
                m = (idx >= change_at) ? late_mode : fm;
                cycle(1'b0, idx == 0, 1'b1, DW'(av(kind, x) + bv(kind, y)), m);
                exp_q.push_back(exp_px(fm, kind, x, y));
                if (gaps && idx % 3 == 2) cycle(1'b0, 1'b0, 1'b0, '0, m);
                if (gaps && idx % 7 == 6) repeat (2) cycle(1'b0, 1'b0, 1'b0, '0, m);
                idx++;
            end
        end
        compare(name);
    endtask

    initial begin
        rst    = 1'b1;
        sof    = 1'b0;
        dval   = 1'b0;
        data   = '0;
        mode   = 2'd0;
        thresh = DW'(THR);
        cycle(1'b1, 1'b0, 1'b0, '0, 2'd0);
        cycle(1'b0, 1'b0, 1'b0, '0, 2'd0);
        check("reset_odata", 32'(o_data), 32'd0);
        check("reset_oborder", 32'(o_border), 32'd0);
        check("reset_odval", 32'(o_dval), 32'd0);

        run_frame("ramp_m0_gaps", 0, 2'd0, 2'd0, 999, 1'b1);
        run_frame("flat_m3", 1, 2'd3, 2'd3, 999, 1'b0);
        run_frame("vstep_m1", 2, 2'd1, 2'd1, 999, 1'b0);
        run_frame("vstep_m2", 2, 2'd2, 2'd2, 999, 1'b0);
        run_frame("vstep_sat_m3", 3, 2'd3, 2'd3, 999, 1'b1);
        run_frame("hstep_m2", 4, 2'd2, 2'd2, 999, 1'b0);
        run_frame("hstep_m1", 4, 2'd1, 2'd1, 999, 1'b0);
        run_frame("mode_change_mid", 2, 2'd1, 2'd2, 12, 1'b0);
        run_frame("mode_after_sof", 2, 2'd2, 2'd2, 999, 1'b0);

        // Reset mid-frame: in-flight pixels vanish and the latched mode reverts to pass-through.
        for (int i = 0; i < 13; i++)
            cycle(1'b0, i == 0, 1'b1, DW'(av(3, i % LW)), 2'd3);
        cycle(1'b1, 1'b0, 1'b0, '0, 2'd3);
        cycle(1'b0, 1'b0, 1'b0, '0, 2'd3);
        check("post_reset_odval", 32'(o_dval), 32'd0);
        out_q.delete();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b1, DW'(100 + 50 * i), 2'd3);
            exp_q.push_back({DW'(100 + 50 * i), 1'b0});
        end
        compare("post_reset_m0");
        run_frame("post_reset_sof_m3", 2, 2'd3, 2'd3, 999, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
